// File: rtl/arm_pkg.sv
// arm_pkg: shared ARM pipeline definitions.
//   - NZCV flag bit indices inside the 4-bit status vector {N,Z,C,V}
//   - condition-code field encodings (EQ .. AL, NV)
//   - common flag write-enable masks
//   - needs_flags(): true when a condition code reads at least one flag
package arm_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Arithmetic ops write all four flags; logical ops leave V alone.
    localparam logic [3:0] MASK_ARITH = 4'b1111;
    localparam logic [3:0] MASK_LOGIC = 4'b1110;

    // AL and NV are decided without looking at the flags; every other
    // code depends on at least one of N, Z, C, V.
    function automatic logic needs_flags(input logic [3:0] cond);
        return !((cond == COND_AL) || (cond == COND_NV));
    endfunction

endpackage

// File: rtl/flag_hazard_detect.sv
// flag_hazard_detect: combinational read-after-write flag hazard check
// between the flag-writing instruction in EXE and the conditional
// instruction in ID.
// Ports:
//   id_valid  in  ID holds a real instruction
//   id_cond   in  ID condition field
//   wr        in  EXE instruction will write the status register
//   haz       out ID instruction reads flags that EXE is about to change
module flag_hazard_detect
    import arm_pkg::*;
(
    input  logic       id_valid,
    input  logic [3:0] id_cond,
    input  logic       wr,
    output logic       haz
);

    // A zero flag_mask still raises a hazard: cheaper than comparing the
    // mask against the bits each condition actually reads.
    assign haz = id_valid & needs_flags(id_cond) & wr;

endmodule

// File: rtl/status_unit.sv
// status_unit: owns the ARM NZCV status register.
//   Commits masked flag updates from S-bit instructions at the end of EXE,
//   presents flags to the ID condition checker and the EXE ALU, resolves the
//   EXE->ID flag hazard (stall or bypass), and counts hazard stall cycles.
// Build option:
//   SR_BYPASS_EN  defined  : sr_id forwards the next flag value, never stalls
//                 undefined: sr_id = register, one-cycle stall per hazard
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   freeze         global stall: holds sr and the stall counter
//   exe_valid/exe_s/exe_cond_pass  qualify the flag write from EXE
//   alu_flags      {N,Z,C,V} from the ALU
//   flag_mask      per-flag write enable, {N,Z,C,V} order
//   id_valid/id_cond  conditional instruction in ID
//   clr_cnt        synchronous clear of stall_cnt (beats increment)
//   sr_id          flags for the ID condition checker
//   sr_exe         registered flags for the ALU carry-in
//   flag_stall     stall request for IF/ID
//   stall_cnt      saturating count of hazard stall cycles
module status_unit
    import arm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             exe_valid,
    input  logic             exe_s,
    input  logic             exe_cond_pass,
    input  logic [3:0]       alu_flags,
    input  logic [3:0]       flag_mask,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             clr_cnt,
    output logic [3:0]       sr_id,
    output logic [3:0]       sr_exe,
    output logic             flag_stall,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [3:0]       sr_reg;
    logic [3:0]       sr_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             wr;

    assign wr = exe_valid & exe_s & exe_cond_pass;

    // Merge each flag individually: masked-off flags keep their old value.
    always_comb begin
        sr_next = sr_reg;
        if (wr) begin
            if (flag_mask[FLAG_N]) sr_next[FLAG_N] = alu_flags[FLAG_N];
            if (flag_mask[FLAG_Z]) sr_next[FLAG_Z] = alu_flags[FLAG_Z];
            if (flag_mask[FLAG_C]) sr_next[FLAG_C] = alu_flags[FLAG_C];
            if (flag_mask[FLAG_V]) sr_next[FLAG_V] = alu_flags[FLAG_V];
        end
    end

    // Under freeze the writer stays in EXE and commits once freeze drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg <= 4'b0000;
        end else if (!freeze) begin
            sr_reg <= sr_next;
        end
    end

    assign sr_exe = sr_reg;

`ifdef SR_BYPASS_EN
    // Forwarding removes the hazard entirely; the counter never moves.
    assign sr_id      = sr_next;
    assign flag_stall = 1'b0;
`else
    logic haz;

    flag_hazard_detect u_haz (
        .id_valid (id_valid),
        .id_cond  (id_cond),
        .wr       (wr),
        .haz      (haz)
    );

    assign sr_id      = sr_reg;
    assign flag_stall = haz;
`endif

    // Saturating counter; clear takes priority and ignores freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr_cnt) begin
            cnt_reg <= '0;
        end else if (flag_stall && !freeze && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = cnt_reg;

endmodule

// File: tb/tb_status_unit.sv
module tb_status_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        exe_valid = 1'b0;
    logic        exe_s = 1'b0;
    logic        exe_cond_pass = 1'b0;
    logic [3:0]  alu_flags = 4'b0;
    logic [3:0]  flag_mask = 4'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  id_cond = 4'b0;
    logic        clr_cnt = 1'b0;

    logic [3:0]  sr_id_a, sr_exe_a, sr_id_b, sr_exe_b;
    logic        flag_stall_a, flag_stall_b;
    logic [15:0] stall_cnt_a;
    logic [1:0]  stall_cnt_b;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [3:0] m_sr;
    int         m_cnt16;
    int         m_cnt2;

    always #5 clk = ~clk;

    status_unit #(.CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .exe_valid(exe_valid),
        .exe_s(exe_s), .exe_cond_pass(exe_cond_pass), .alu_flags(alu_flags),
        .flag_mask(flag_mask), .id_valid(id_valid), .id_cond(id_cond),
        .clr_cnt(clr_cnt), .sr_id(sr_id_a), .sr_exe(sr_exe_a),
        .flag_stall(flag_stall_a), .stall_cnt(stall_cnt_a)
    );

    status_unit #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .exe_valid(exe_valid),
        .exe_s(exe_s), .exe_cond_pass(exe_cond_pass), .alu_flags(alu_flags),
        .flag_mask(flag_mask), .id_valid(id_valid), .id_cond(id_cond),
        .clr_cnt(clr_cnt), .sr_id(sr_id_b), .sr_exe(sr_exe_b),
        .flag_stall(flag_stall_b), .stall_cnt(stall_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_wr();
        return exe_valid && exe_s && exe_cond_pass;
    endfunction

    function automatic bit m_haz();
        return id_valid && m_wr() && (id_cond != 4'd14) && (id_cond != 4'd15);
    endfunction

    // Check combinational outputs against the model, then clock and advance it.
    task automatic cycle(input string tag);
        bit haz;
        #1;
        haz = m_haz();
        check({tag, ".stall"},   {31'b0, flag_stall_a}, {31'b0, haz});
        check({tag, ".stall_b"}, {31'b0, flag_stall_b}, {31'b0, haz});
        check({tag, ".sr_id"},   {28'b0, sr_id_a},  {28'b0, m_sr});
        check({tag, ".sr_exe"},  {28'b0, sr_exe_b}, {28'b0, m_sr});
        check({tag, ".cnt16"},   {16'b0, stall_cnt_a}, m_cnt16);
        check({tag, ".cnt2"},    {30'b0, stall_cnt_b}, m_cnt2);
        $display("[TB] %s frz=%0b wr=%0b alu=%b msk=%b idv=%0b cond=%h clr=%0b | sr=%b stall=%0b cnt=%0d/%0d",
                 tag, freeze, m_wr(), alu_flags, flag_mask, id_valid, id_cond, clr_cnt,
                 sr_exe_a, flag_stall_a, stall_cnt_a, stall_cnt_b);
        @(posedge clk);
        if (!freeze && m_wr())
            for (int i = 0; i < 4; i++)
                if (flag_mask[i]) m_sr[i] = alu_flags[i];
        if (clr_cnt) begin
            m_cnt16 = 0;
            m_cnt2  = 0;
        end else if (haz && !freeze) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        freeze = 0; exe_valid = 0; exe_s = 0; exe_cond_pass = 0;
        alu_flags = 0; flag_mask = 0; id_valid = 0; id_cond = 0; clr_cnt = 0;
    endtask

    task automatic set_wr(input logic [3:0] f, input logic [3:0] m);
        exe_valid = 1; exe_s = 1; exe_cond_pass = 1; alu_flags = f; flag_mask = m;
    endtask

    // Assert reset between clock edges and check the asynchronous clear.
    task automatic do_reset();
        #2;
        idle_inputs();
        rst_n = 0;
        #1;
        check("rst.sr_exe", {28'b0, sr_exe_a}, 32'h0);
        check("rst.cnt16", {16'b0, stall_cnt_a}, 32'h0);
        check("rst.cnt2", {30'b0, stall_cnt_b}, 32'h0);
        check("rst.stall", {31'b0, flag_stall_a}, 32'h0);
        $display("[TB] reset asserted sr=%b cnt=%0d", sr_exe_a, stall_cnt_a);
        m_sr = 4'b0; m_cnt16 = 0; m_cnt2 = 0;
        @(posedge clk);
        #2;
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        m_sr = 4'b0; m_cnt16 = 0; m_cnt2 = 0;
        do_reset();

        // Hazard without bypass
        set_wr(4'b0100, 4'b1111); id_valid = 1; id_cond = 4'b0000;
        #1 check("haz.stall_now", {31'b0, flag_stall_a}, 32'h1);
        cycle("haz0");
        exe_valid = 0;
        #1;
        check("haz.stall_after", {31'b0, flag_stall_a}, 32'h0);
        check("haz.sr_id", {28'b0, sr_id_a}, 32'h4);
        check("haz.cnt", {16'b0, stall_cnt_a}, 32'h1);
        cycle("haz1");

        // Masked write preserving V
        idle_inputs();
        set_wr(4'b0001, 4'b1111); cycle("mw0");
        set_wr(4'b1100, 4'b1110); cycle("mw1");
        idle_inputs();
        check("mask.sr_exe", {28'b0, sr_exe_a}, 32'hD);
        cycle("mw2");

        // Zero mask: unchanged but still a hazard
        set_wr(4'b0010, 4'b0000); id_valid = 1; id_cond = 4'b0101;
        cycle("zmask");
        check("zmask.sr_exe", {28'b0, sr_exe_a}, 32'hD);

        // AL / NV never stall
        set_wr(4'b1010, 4'b1111); id_valid = 1;
        id_cond = 4'b1110; #1 check("al.stall", {31'b0, flag_stall_a}, 32'h0); cycle("al");
        id_cond = 4'b1111; #1 check("nv.stall", {31'b0, flag_stall_a}, 32'h0); cycle("nv");

        // Freeze holds sr and counter, write lands when freeze drops
        idle_inputs();
        set_wr(4'b0000, 4'b1111); cycle("fz_pre");
        freeze = 1; set_wr(4'b1111, 4'b1111); id_valid = 1; id_cond = 4'b0001;
        cycle("fz0");
        check("fz.sr_hold", {28'b0, sr_exe_a}, 32'h0);
        cycle("fz1");
        freeze = 0;
        cycle("fz2");
        check("fz.sr_land", {28'b0, sr_exe_a}, 32'hF);

        // Saturation on the 2-bit counter, then clear beats increment
        do_reset();
        set_wr(4'b0110, 4'b1111); id_valid = 1; id_cond = 4'b1010;
        for (int i = 0; i < 5; i++) cycle("sat");
        check("sat.cnt2", {30'b0, stall_cnt_b}, 32'h3);
        clr_cnt = 1; cycle("clr");
        check("clr.cnt2", {30'b0, stall_cnt_b}, 32'h0);
        check("clr.cnt16", {16'b0, stall_cnt_a}, 32'h0);
        clr_cnt = 0;

        // Randomized traffic with a mid-run reset
        for (int n = 0; n < 400; n++) begin
            freeze        = ($urandom_range(0, 3) == 0);
            exe_valid     = ($urandom_range(0, 4) != 0);
            exe_s         = $urandom_range(0, 1);
            exe_cond_pass = ($urandom_range(0, 3) != 0);
            alu_flags     = 4'($urandom);
            flag_mask     = 4'($urandom);
            id_valid      = ($urandom_range(0, 4) != 0);
            id_cond       = 4'($urandom);
            clr_cnt       = ($urandom_range(0, 31) == 0);
            cycle("rnd");
            if (n == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
